// File: rtl/lsu_pkg.sv
// Shared types and funct3 size encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapt,
        StResp
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational request decode: legality, aligned address, lane-replicated store data, size flags.
// LSU_MISALIGN_TRAP_EN makes misaligned H/HU/W illegal; otherwise they are silently aligned down.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned MemSize = 1024
) (
    input  logic [2:0]  funct3_i,
    input  logic        store_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        legal_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic        byte_o,
    output logic        hwrd_o,
    output logic        rdu_o
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapMisalign = 1'b1;
`else
    localparam bit TrapMisalign = 1'b0;
`endif

    localparam logic [32:0] AddrLimit = 33'(MemSize) << 2;

    logic f3_ok;
    logic misalign;
    logic out_of_range;

    // Range check uses the raw address, before any silent alignment.
    assign out_of_range = {1'b0, addr_i} >= AddrLimit;

    always_comb begin
        f3_ok    = 1'b0;
        misalign = 1'b0;
        byte_o   = 1'b0;
        hwrd_o   = 1'b0;
        rdu_o    = 1'b0;
        addr_o   = addr_i;
        wdata_o  = wdata_i;
        case (funct3_i)
            F3_B: begin
                f3_ok   = 1'b1;
                byte_o  = 1'b1;
                wdata_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                f3_ok     = 1'b1;
                hwrd_o    = 1'b1;
                wdata_o   = {2{wdata_i[15:0]}};
                misalign  = addr_i[0];
                addr_o[0] = 1'b0;
            end
            F3_W: begin
                f3_ok       = 1'b1;
                misalign    = |addr_i[1:0];
                addr_o[1:0] = 2'b00;
            end
            F3_BU: begin
                f3_ok  = !store_i;
                byte_o = 1'b1;
                rdu_o  = 1'b1;
            end
            F3_HU: begin
                f3_ok     = !store_i;
                hwrd_o    = 1'b1;
                rdu_o     = 1'b1;
                misalign  = addr_i[0];
                addr_o[0] = 1'b0;
            end
            default: f3_ok = 1'b0;
        endcase
    end

    assign legal_o = f3_ok && !out_of_range && !(TrapMisalign && misalign);

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: IDLE -> ISSUE -> (CAPT) -> RESP, all dmem outputs registered.
// Build option LSU_MISALIGN_TRAP_EN (see lsu_align) selects trapping vs. aligning misaligned ops.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEMSIZE = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_store,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [4:0]  i_req_rd,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_data,
    output logic [4:0]  o_resp_rd,
    output logic        o_resp_err,
    output logic        o_dmem_write,
    output logic        o_dmem_rdu,
    output logic        o_dmem_byte,
    output logic        o_dmem_hwrd,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic [31:0] i_dmem_result
);

    lsu_state_e  state_q, state_d;
    logic        store_q, store_d;
    logic        err_q, err_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        byte_q, byte_d;
    logic        hwrd_q, hwrd_d;
    logic        rdu_q, rdu_d;

    logic        al_legal;
    logic [31:0] al_addr;
    logic [31:0] al_wdata;
    logic        al_byte;
    logic        al_hwrd;
    logic        al_rdu;

    lsu_align #(
        .MemSize (MEMSIZE)
    ) u_align (
        .funct3_i (i_req_funct3),
        .store_i  (i_req_store),
        .addr_i   (i_req_addr),
        .wdata_i  (i_req_wdata),
        .legal_o  (al_legal),
        .addr_o   (al_addr),
        .wdata_o  (al_wdata),
        .byte_o   (al_byte),
        .hwrd_o   (al_hwrd),
        .rdu_o    (al_rdu)
    );

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        err_d       = err_q;
        rd_d        = rd_q;
        resp_data_d = resp_data_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        byte_d      = byte_q;
        hwrd_d      = hwrd_q;
        rdu_d       = rdu_q;
        unique case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    store_d     = i_req_store;
                    rd_d        = i_req_rd;
                    err_d       = !al_legal;
                    resp_data_d = '0;
                    // Illegal ops leave the dmem-facing registers at their last values.
                    if (al_legal) begin
                        addr_d  = al_addr;
                        wdata_d = al_wdata;
                        byte_d  = al_byte;
                        hwrd_d  = al_hwrd;
                        rdu_d   = al_rdu;
                        state_d = StIssue;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StIssue: state_d = store_q ? StResp : StCapt;
            StCapt: begin
                resp_data_d = i_dmem_result;
                state_d     = StResp;
            end
            StResp: begin
                if (i_resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            store_q     <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= '0;
            resp_data_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            byte_q      <= 1'b0;
            hwrd_q      <= 1'b0;
            rdu_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
            resp_data_q <= resp_data_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byte_q      <= byte_d;
            hwrd_q      <= hwrd_d;
            rdu_q       <= rdu_d;
        end
    end

    assign o_req_ready  = (state_q == StIdle);
    assign o_resp_valid = (state_q == StResp);
    assign o_resp_data  = resp_data_q;
    assign o_resp_rd    = rd_q;
    assign o_resp_err   = err_q;
    assign o_dmem_write = (state_q == StIssue) && store_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_wdata = wdata_q;
    assign o_dmem_byte  = byte_q;
    assign o_dmem_hwrd  = hwrd_q;
    assign o_dmem_rdu   = rdu_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus random ops, checked against a byte-level memory model.
module tb_lsu;

    localparam int MEMSIZE = 1024;
    localparam int AW      = $clog2(MEMSIZE);

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_store = 1'b0;
    logic [2:0]  i_req_funct3 = 3'b0;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic [4:0]  i_req_rd = '0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b0;
    logic [31:0] o_resp_data;
    logic [4:0]  o_resp_rd;
    logic        o_resp_err;
    logic        o_dmem_write;
    logic        o_dmem_rdu;
    logic        o_dmem_byte;
    logic        o_dmem_hwrd;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [31:0] i_dmem_result;

    int checks   = 0;
    int failures = 0;

    lsu #(
        .MEMSIZE (MEMSIZE)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_store   (i_req_store),
        .i_req_funct3  (i_req_funct3),
        .i_req_addr    (i_req_addr),
        .i_req_wdata   (i_req_wdata),
        .i_req_rd      (i_req_rd),
        .o_resp_valid  (o_resp_valid),
        .i_resp_ready  (i_resp_ready),
        .o_resp_data   (o_resp_data),
        .o_resp_rd     (o_resp_rd),
        .o_resp_err    (o_resp_err),
        .o_dmem_write  (o_dmem_write),
        .o_dmem_rdu    (o_dmem_rdu),
        .o_dmem_byte   (o_dmem_byte),
        .o_dmem_hwrd   (o_dmem_hwrd),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wdata  (o_dmem_wdata),
        .i_dmem_result (i_dmem_result)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $fatal(1, "FAIL global_timeout");
    end

    // ---------------- dmem environment model (word array with lane enables) ----------------
    logic [31:0] dmem [MEMSIZE];
    logic        init_mem = 1'b1;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_5A5A;
    endfunction

    always @(posedge i_clk) begin
        if (init_mem) begin
            for (int i = 0; i < MEMSIZE; i++) dmem[i] <= init_word(i);
        end else if (o_dmem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (o_dmem_byte ? (b == int'(o_dmem_addr[1:0])) :
                    o_dmem_hwrd ? ((b / 2) == int'(o_dmem_addr[1])) : 1'b1)
                    dmem[o_dmem_addr[AW+1:2]][8*b +: 8] <= o_dmem_wdata[8*b +: 8];
            end
        end
    end

    logic [31:0] rd_word;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;
    always_comb begin
        rd_word = dmem[o_dmem_addr[AW+1:2]];
        rd_b    = rd_word[{o_dmem_addr[1:0], 3'b000} +: 8];
        rd_h    = rd_word[{o_dmem_addr[1], 4'b0000} +: 16];
        if (o_dmem_byte)      i_dmem_result = o_dmem_rdu ? {24'b0, rd_b} : {{24{rd_b[7]}}, rd_b};
        else if (o_dmem_hwrd) i_dmem_result = o_dmem_rdu ? {16'b0, rd_h} : {{16{rd_h[15]}}, rd_h};
        else                  i_dmem_result = rd_word;
    end

    // ---------------- reference model: flat byte memory ----------------
    logic [7:0] ref_mem [MEMSIZE*4];

    function automatic int op_size(logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic ref_err(logic st, logic [2:0] f3, logic [31:0] a);
        logic bad;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]) ||
              (a >= 32'(MEMSIZE * 4));
`ifdef LSU_MISALIGN_TRAP_EN
        if ((a % 32'(op_size(f3))) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic int ref_ea(logic [2:0] f3, logic [31:0] a);
        int sz = op_size(f3);
        return int'(a) - (int'(a) % sz);
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
        int          sz = op_size(f3);
        int          ea = ref_ea(f3, a);
        logic [31:0] v  = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[ea + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        int sz = op_size(f3);
        int ea = ref_ea(f3, a);
        for (int i = 0; i < sz; i++) ref_mem[ea + i] = 8'(wd >> (8 * i));
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic scramble_req();
        i_req_store  = 1'($urandom);
        i_req_funct3 = 3'($urandom);
        i_req_addr   = $urandom;
        i_req_wdata  = $urandom;
        i_req_rd     = 5'($urandom);
    endtask

    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input int hold);
        logic        e_err;
        logic [31:0] e_data;
        logic [31:0] e_wdata;
        int          e_lat;
        int          lat;
        int          nwr;
        e_err   = ref_err(st, f3, a);
        e_data  = (!st && !e_err) ? ref_load(f3, a) : 32'd0;
        e_lat   = e_err ? 1 : (st ? 2 : 3);
        e_wdata = (op_size(f3) == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
                  (op_size(f3) == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
        check("req_ready_idle", 32'(o_req_ready), 32'd1);
        i_req_valid  = 1'b1;
        i_req_store  = st;
        i_req_funct3 = f3;
        i_req_addr   = a;
        i_req_wdata  = wd;
        i_req_rd     = rd;
        tick();
        i_req_valid = 1'b0;
        scramble_req();
        lat = 1;
        nwr = 0;
        while (!o_resp_valid && lat < 8) begin
            if (o_dmem_write) begin
                nwr++;
                check("dmem_addr", o_dmem_addr, 32'(ref_ea(f3, a)));
                check("dmem_wdata", o_dmem_wdata, e_wdata);
            end
            tick();
            lat++;
        end
        if (o_dmem_write) nwr++;
        if (st && !e_err) ref_store(f3, a, wd);
        check("resp_latency", 32'(lat), 32'(e_lat));
        check("write_count", 32'(nwr), (st && !e_err) ? 32'd1 : 32'd0);
        check("resp_err", 32'(o_resp_err), 32'(e_err));
        check("resp_data", o_resp_data, e_data);
        check("resp_rd", 32'(o_resp_rd), 32'(rd));
        for (int k = 0; k < hold; k++) begin
            tick();
            check("hold_valid", 32'(o_resp_valid), 32'd1);
            check("hold_data", o_resp_data, e_data);
            check("hold_ready", 32'(o_req_ready), 32'd0);
        end
        // Offer a new request in the same cycle the response is consumed: must not be taken.
        i_resp_ready = 1'b1;
        i_req_valid  = 1'b1;
        check("ready_in_resp", 32'(o_req_ready), 32'd0);
        tick();
        i_resp_ready = 1'b0;
        i_req_valid  = 1'b0;
        check("back_idle_ready", 32'(o_req_ready), 32'd1);
        check("back_idle_valid", 32'(o_resp_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < MEMSIZE; i++)
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = 8'(init_word(i) >> (8 * b));

        tick();
        tick();
        i_rst    = 1'b0;
        init_mem = 1'b0;
        check("rst_req_ready", 32'(o_req_ready), 32'd1);
        check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        check("rst_resp_err", 32'(o_resp_err), 32'd0);
        check("rst_resp_data", o_resp_data, 32'd0);
        check("rst_resp_rd", 32'(o_resp_rd), 32'd0);
        check("rst_dmem_write", 32'(o_dmem_write), 32'd0);
        check("rst_dmem_addr", o_dmem_addr, 32'd0);
        check("rst_dmem_wdata", o_dmem_wdata, 32'd0);
        check("rst_dmem_flags", {29'd0, o_dmem_rdu, o_dmem_byte, o_dmem_hwrd}, 32'd0);

        // SW / LW round trip
        do_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd3, 0);
        do_op(1'b0, 3'b010, 32'h10, 32'h0, 5'd4, 0);
        check("lw_deadbeef", o_resp_data, 32'hDEAD_BEEF);

        // SB then signed/unsigned byte loads, neighbours intact
        do_op(1'b1, 3'b000, 32'h13, 32'h0000_0080, 5'd5, 0);
        do_op(1'b0, 3'b000, 32'h13, 32'h0, 5'd6, 0);
        check("lb_sext", o_resp_data, 32'hFFFF_FF80);
        do_op(1'b0, 3'b100, 32'h13, 32'h0, 5'd7, 0);
        check("lbu_zext", o_resp_data, 32'h0000_0080);
        do_op(1'b0, 3'b010, 32'h10, 32'h0, 5'd8, 0);
        check("lw_after_sb", o_resp_data, 32'h80AD_BEEF);

        // Halfword loads, aligned and misaligned
        do_op(1'b1, 3'b010, 32'h10, 32'h1234_5678, 5'd9, 0);
        do_op(1'b0, 3'b001, 32'h12, 32'h0, 5'd10, 0);
        check("lh_aligned", o_resp_data, 32'h0000_1234);
        do_op(1'b0, 3'b001, 32'h11, 32'h0, 5'd11, 0);

        // Out-of-range load and store, illegal funct3 encodings
        do_op(1'b0, 3'b010, 32'(MEMSIZE * 4), 32'h0, 5'd12, 0);
        check("oor_err", 32'(o_resp_err), 32'd1);
        do_op(1'b1, 3'b010, 32'(MEMSIZE * 4), 32'h5555_5555, 5'd13, 0);
        do_op(1'b1, 3'b101, 32'h20, 32'h1111_1111, 5'd14, 0);
        do_op(1'b0, 3'b011, 32'h20, 32'h0, 5'd15, 0);

        // Backpressure: response held 5 cycles
        do_op(1'b0, 3'b010, 32'h10, 32'h0, 5'd16, 5);

        // Reset during CAPT drops the load
        i_req_valid  = 1'b1;
        i_req_store  = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h10;
        i_req_rd     = 5'd17;
        tick();
        i_req_valid = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("capt_rst_ready", 32'(o_req_ready), 32'd1);
        check("capt_rst_valid", 32'(o_resp_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("capt_rst_quiet", 32'(o_resp_valid), 32'd0);
        end

        // Reset during ISSUE of a store: strobe already seen, not repeated
        i_req_valid  = 1'b1;
        i_req_store  = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h20;
        i_req_wdata  = 32'hCAFE_F00D;
        tick();
        i_req_valid = 1'b0;
        check("issue_write_strobe", 32'(o_dmem_write), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        ref_store(3'b010, 32'h20, 32'hCAFE_F00D);
        check("issue_rst_write_off", 32'(o_dmem_write), 32'd0);
        check("issue_rst_ready", 32'(o_req_ready), 32'd1);
        do_op(1'b0, 3'b010, 32'h20, 32'h0, 5'd18, 0);

        // Random mix against the byte model
        for (int n = 0; n < 150; n++) begin
            logic [31:0] ra;
            ra = (($urandom % 16) == 0) ? 32'(MEMSIZE * 4) + ($urandom % 64) : ($urandom % 64);
            do_op(1'($urandom), 3'($urandom), ra, $urandom, 5'($urandom), int'($urandom % 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter: MEMSIZE, 1024, number of 32-bit words in the attached dmem; byte addresses >= MEMSIZE*4 are out of range.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports (name  direction  width  meaning):
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  pipeline presents a memory op
- o_req_ready  out  1  LSU accepts op this cycle
- i_req_store  in  1  1=store, 0=load
- i_req_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-justified
- i_req_rd  in  5  destination register tag
- o_resp_valid  out  1  response available
- i_resp_ready  in  1  pipeline consumes response
- o_resp_data  out  32  extended load data; 0 for stores
- o_resp_rd  out  5  echoed tag
- o_resp_err  out  1  misaligned or out-of-range access
- o_dmem_write  out  1  dmem write strobe
- o_dmem_rdu  out  1  unsigned load
- o_dmem_byte  out  1  byte-size access
- o_dmem_hwrd  out  1  halfword-size access
- o_dmem_addr  out  32  dmem byte address
- o_dmem_wdata  out  32  store data replicated into all lanes
- i_dmem_result  in  32  extended read result from dmem

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, CAPT, RESP.
REQ-005 SHALL assert o_req_ready only in IDLE; handshake is i_req_valid && o_req_ready.
REQ-006 SHALL register addr, wdata, funct3, store, and rd on acceptance; all o_dmem_* outputs SHALL derive only from the state and these registers, with no combinational path from i_req_*.
REQ-007 IDLE + accepted legal op -> ISSUE; IDLE + accepted illegal op -> RESP with o_resp_err=1 and no dmem access.
REQ-008 ISSUE: o_dmem_addr, size, and rdu driven; o_dmem_write=1 only for stores, for exactly one cycle; a store goes to RESP and a load goes to CAPT.
REQ-009 CAPT: o_dmem_addr/byte/hwrd/rdu SHALL be held equal to the ISSUE values, with o_dmem_write=0, and i_dmem_result latched into o_resp_data; -> RESP.
REQ-010 RESP: o_resp_valid=1, with data, rd, and err stable until i_resp_ready; RESP && i_resp_ready -> IDLE; the next op is not accepted in that same cycle.
REQ-011 Minimum latency, acceptance to o_resp_valid: load 3 cycles, store 2 cycles, illegal 1 cycle.
REQ-012 o_dmem_wdata SHALL be {4{b}} for B, {2{h}} for H, and unchanged for W.
REQ-013 o_dmem_byte=1 for B/BU and o_dmem_hwrd=1 for H/HU, mutually exclusive; o_dmem_rdu=1 for BU/HU.
REQ-014 Store with funct3 BU/HU, or funct3 011/11x, SHALL be illegal (err=1).
REQ-015 Out-of-range address SHALL be illegal regardless of configuration.
REQ-016 Outside ISSUE/CAPT, o_dmem_write=0 and the other o_dmem_* outputs are don't-care-but-stable (held at last values).

Reset
REQ-017 i_rst SHALL force IDLE on the next edge and abort any in-flight op; a pending response is dropped.
REQ-018 After reset: o_req_ready=1, o_resp_valid=0, o_resp_err=0, o_resp_data=0, o_resp_rd=0, o_dmem_write=0, o_dmem_addr=0, o_dmem_wdata=0, rdu/byte/hwrd=0.
REQ-019 Reset asserted in ISSUE SHALL suppress o_dmem_write from the following cycle; a write already strobed is not undone.

Configuration
REQ-020 Macro LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, SHALL be illegal (err=1, no access).
REQ-021 Macro undefined: misaligned addresses SHALL be silently aligned (H clears bit 0, W clears bits 1:0) before ISSUE, and misalignment never sets err.

Structure
REQ-022 Package lsu_pkg SHALL hold the FSM state enum and the funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-023 Sub-module lsu_align SHALL be purely combinational, computing legality, the aligned address, lane-replicated wdata, and size flags from funct3/addr/wdata.

Verification
REQ-024 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> store response at +2 cycles, err=0; load o_resp_data=0xDEADBEEF at +3 cycles.
REQ-025 SB 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; other bytes of word 0x10 unchanged.
REQ-026 LH addr 0x12 with word 0x12345678 at 0x10 -> 0x00001234; LH addr 0x11 -> err=1 with macro; without macro -> 0x00005678, err=0.
REQ-027 LW addr MEMSIZE*4 -> err=1 at +1 cycle, o_dmem_write never asserted.
REQ-028 Load with i_resp_ready held low 5 cycles -> o_resp_valid and data stable for all 5 cycles, o_req_ready=0 throughout.
REQ-029 Reset asserted during CAPT -> IDLE next cycle, o_resp_valid never asserted, o_req_ready=1.
